// File: rtl/letc_pkg.sv
// rtl/letc_pkg.sv - shared AXI response/burst encodings and latched request type
package letc_pkg;

  localparam int AXI_ID_W = 4;

  typedef enum logic [1:0] {
    AXI_RESP_OKAY   = 2'd0,
    AXI_RESP_EXOKAY = 2'd1,
    AXI_RESP_SLVERR = 2'd2,
    AXI_RESP_DECERR = 2'd3
  } axi_resp_e;

  typedef enum logic [1:0] {
    AXI_BURST_FIXED = 2'd0,
    AXI_BURST_INCR  = 2'd1,
    AXI_BURST_WRAP  = 2'd2
  } axi_burst_e;

  typedef struct packed {
    logic [AXI_ID_W-1:0] id;
    logic [31:0]         addr;
    logic [7:0]          len;
    logic [2:0]          size;
    logic [1:0]          burst;
  } axi_req_t;

  // Numeric order of the codes matches their severity (DECERR > SLVERR > OKAY).
  function automatic axi_resp_e resp_max(input axi_resp_e a, input axi_resp_e b);
    if (a > b) return a;
    return b;
  endfunction

endpackage

// File: rtl/axi_if.sv
// rtl/axi_if.sv - AXI4 bundle (AW/W/B/AR/R) with manager and subordinate views
interface axi_if #(
  parameter int ID_W = letc_pkg::AXI_ID_W
) ();

  logic            awvalid, awready;
  logic [ID_W-1:0] awid;
  logic [31:0]     awaddr;
  logic [7:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;

  logic            wvalid, wready;
  logic [31:0]     wdata;
  logic [3:0]      wstrb;
  logic            wlast;

  logic            bvalid, bready;
  logic [ID_W-1:0] bid;
  logic [1:0]      bresp;

  logic            arvalid, arready;
  logic [ID_W-1:0] arid;
  logic [31:0]     araddr;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;

  logic            rvalid, rready;
  logic [ID_W-1:0] rid;
  logic [31:0]     rdata;
  logic [1:0]      rresp;
  logic            rlast;

  modport subordinate (
    input  awvalid, awid, awaddr, awlen, awsize, awburst, output awready,
    input  wvalid, wdata, wstrb, wlast, output wready,
    output bvalid, bid, bresp, input bready,
    input  arvalid, arid, araddr, arlen, arsize, arburst, output arready,
    output rvalid, rid, rdata, rresp, rlast, input rready
  );

  modport manager (
    output awvalid, awid, awaddr, awlen, awsize, awburst, input awready,
    output wvalid, wdata, wstrb, wlast, input wready,
    input  bvalid, bid, bresp, output bready,
    output arvalid, arid, araddr, arlen, arsize, arburst, input arready,
    input  rvalid, rid, rdata, rresp, rlast, output rready
  );

endinterface

// File: rtl/letc_sram_1rw.sv
// rtl/letc_sram_1rw.sv - single-port 32-bit SRAM, byte write enables, 1-cycle registered read
module letc_sram_1rw #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_en,
  input  logic [3:0]    i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rdata;

  // Output register only updates on a read access, so it holds between reads.
  always_ff @(posedge i_clk) begin
    if (i_en) begin
      if (i_we == 4'd0) r_rdata <= r_mem[i_addr];
      for (int b = 0; b < 4; b++) begin
        if (i_we[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/letc_axi_sram_sub.sv
// rtl/letc_axi_sram_sub.sv - AXI4 subordinate in front of an on-chip SRAM, one transaction at a time
// WRAP bursts are built only when LETC_AXI_SRAM_SUB_WRAP_BURST_EN is defined.
module letc_axi_sram_sub
  import letc_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 1024
) (
  input  logic       i_clk,
  input  logic       i_rst,
  axi_if.subordinate axi
);

  localparam int          AW         = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN_BYTES = 32'(4 * DEPTH_WORDS);

  typedef enum logic [2:0] {IDLE, W_DATA, W_RESP, R_FETCH, R_DATA} state_e;

  function automatic logic [31:0] next_addr(input axi_req_t req);
    logic [31:0] inc;
    inc = 32'd1 << req.size;
    case (req.burst)
      AXI_BURST_INCR: next_addr = req.addr + inc;
`ifdef LETC_AXI_SRAM_SUB_WRAP_BURST_EN
      AXI_BURST_WRAP: begin
        logic [31:0] mask;
        mask      = (({24'd0, req.len} + 32'd1) << req.size) - 32'd1;
        next_addr = (req.addr & ~mask) | ((req.addr + inc) & mask);
      end
`endif
      default:        next_addr = req.addr;
    endcase
  endfunction

  function automatic logic req_bad(input axi_req_t req);
    logic bad;
    bad = (req.size > 3'd2) || (req.burst == 2'b11);
`ifdef LETC_AXI_SRAM_SUB_WRAP_BURST_EN
    if (req.burst == 2'b10 && !(req.len inside {8'd1, 8'd3, 8'd7, 8'd15})) bad = 1'b1;
`else
    if (req.burst == 2'b10) bad = 1'b1;
`endif
    return bad;
  endfunction

  state_e    r_state, w_state_n;
  axi_req_t  r_req;
  logic      r_bad;
  logic [8:0] r_beat;
  axi_resp_e r_err;
  logic      r_arb, w_arb_n;
  logic      r_awready, r_arready, w_awready_n, w_arready_n;
  logic      r_wready, r_bvalid, r_rvalid, r_rlast, r_rzero;
  axi_resp_e r_bresp, r_rresp;
  logic [AXI_ID_W-1:0] r_bid, r_rid;

  axi_req_t  w_aw_req, w_ar_req, w_new_req;
  logic      w_aw_hs, w_ar_hs, w_w_hs;
  logic [31:0] w_offset, w_sram_q;
  logic      w_in_range, w_beat_ok, w_write_ok, w_sram_en;
  logic [3:0] w_sram_we;
  axi_resp_e w_wbeat_resp, w_rbeat_resp;

  assign w_aw_req  = '{id: axi.awid, addr: axi.awaddr, len: axi.awlen, size: axi.awsize, burst: axi.awburst};
  assign w_ar_req  = '{id: axi.arid, addr: axi.araddr, len: axi.arlen, size: axi.arsize, burst: axi.arburst};
  assign w_new_req = w_aw_hs ? w_aw_req : w_ar_req;

  assign w_aw_hs = r_awready && axi.awvalid;
  assign w_ar_hs = r_arready && axi.arvalid;
  assign w_w_hs  = r_wready && axi.wvalid;

  assign w_offset   = r_req.addr - BASE_ADDR;
  assign w_in_range = w_offset < SPAN_BYTES;
  assign w_beat_ok  = r_beat <= {1'b0, r_req.len};
  assign w_write_ok = w_in_range && !r_bad && w_beat_ok;

  always_comb begin
    w_wbeat_resp = AXI_RESP_OKAY;
    if (!w_in_range) w_wbeat_resp = AXI_RESP_DECERR;
    else if (r_bad || !w_beat_ok || (axi.wlast && r_beat != {1'b0, r_req.len}))
      w_wbeat_resp = AXI_RESP_SLVERR;
  end

  always_comb begin
    w_rbeat_resp = AXI_RESP_OKAY;
    if (!w_in_range) w_rbeat_resp = AXI_RESP_DECERR;
    else if (r_bad)  w_rbeat_resp = AXI_RESP_SLVERR;
  end

  assign w_sram_en = (r_state == R_FETCH) || (r_state == W_DATA && w_w_hs && w_write_ok);
  assign w_sram_we = (r_state == W_DATA) ? (axi.wstrb & {4{w_write_ok}}) : 4'd0;

  letc_sram_1rw #(.DEPTH(DEPTH_WORDS)) u_sram (
    .i_clk   (i_clk),
    .i_en    (w_sram_en),
    .i_we    (w_sram_we),
    .i_addr  (AW'(w_offset >> 2)),
    .i_wdata (axi.wdata),
    .o_rdata (w_sram_q)
  );

  // Readies are registered grants: recomputed every idle cycle that has no handshake.
  always_comb begin
    w_state_n   = r_state;
    w_awready_n = 1'b0;
    w_arready_n = 1'b0;
    w_arb_n     = r_arb;
    case (r_state)
      IDLE: begin
        if (w_aw_hs)      w_state_n = W_DATA;
        else if (w_ar_hs) w_state_n = R_FETCH;
        else if (axi.awvalid && axi.arvalid) begin
          w_awready_n = ~r_arb;
          w_arready_n = r_arb;
          w_arb_n     = ~r_arb;
        end else begin
          w_awready_n = axi.awvalid;
          w_arready_n = axi.arvalid;
        end
      end
      W_DATA:  if (w_w_hs && axi.wlast) w_state_n = W_RESP;
      W_RESP:  if (r_bvalid && axi.bready) w_state_n = IDLE;
      R_FETCH: w_state_n = R_DATA;
      R_DATA:  if (r_rvalid && axi.rready) w_state_n = r_rlast ? IDLE : R_FETCH;
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_awready <= 1'b0;
      r_arready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rzero   <= 1'b1;
      r_arb     <= 1'b0;
      r_bresp   <= AXI_RESP_OKAY;
      r_rresp   <= AXI_RESP_OKAY;
      r_bid     <= '0;
      r_rid     <= '0;
      r_req     <= '0;
      r_bad     <= 1'b0;
      r_beat    <= '0;
      r_err     <= AXI_RESP_OKAY;
    end else begin
      r_state   <= w_state_n;
      r_awready <= w_awready_n;
      r_arready <= w_arready_n;
      r_arb     <= w_arb_n;
      r_wready  <= (w_state_n == W_DATA);
      r_bvalid  <= (w_state_n == W_RESP);
      r_rvalid  <= (w_state_n == R_DATA);
      case (r_state)
        IDLE: begin
          if (w_aw_hs || w_ar_hs) begin
            r_req  <= w_new_req;
            r_bad  <= req_bad(w_new_req);
            r_beat <= '0;
            r_err  <= AXI_RESP_OKAY;
          end
        end
        W_DATA: begin
          if (w_w_hs) begin
            r_err      <= resp_max(r_err, w_wbeat_resp);
            r_req.addr <= next_addr(r_req);
            if (w_beat_ok) r_beat <= r_beat + 9'd1;
            if (axi.wlast) begin
              r_bresp <= resp_max(r_err, w_wbeat_resp);
              r_bid   <= r_req.id;
            end
          end
        end
        R_FETCH: begin
          r_rresp <= w_rbeat_resp;
          r_rzero <= (w_rbeat_resp != AXI_RESP_OKAY);
          r_rlast <= (r_beat == {1'b0, r_req.len});
          r_rid   <= r_req.id;
        end
        R_DATA: begin
          if (r_rvalid && axi.rready) begin
            r_beat     <= r_beat + 9'd1;
            r_req.addr <= next_addr(r_req);
          end
        end
        default: ;
      endcase
    end
  end

  assign axi.awready = r_awready;
  assign axi.arready = r_arready;
  assign axi.wready  = r_wready;
  assign axi.bvalid  = r_bvalid;
  assign axi.bresp   = r_bresp;
  assign axi.bid     = r_bid;
  assign axi.rvalid  = r_rvalid;
  assign axi.rresp   = r_rresp;
  assign axi.rid     = r_rid;
  assign axi.rlast   = r_rlast;
  // SRAM output register holds until the next fetch; errored beats are forced to zero.
  assign axi.rdata   = r_rzero ? 32'd0 : w_sram_q;

endmodule

// File: tb/tb_letc_axi_sram_sub.sv
// tb/tb_letc_axi_sram_sub.sv - directed self-checking bench for letc_axi_sram_sub
module tb_letc_axi_sram_sub;
  import letc_pkg::*;

  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam int          DEPTH = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  axi_if axi_bus ();

  letc_axi_sram_sub #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .axi   (axi_bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic aw_send(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [3:0] id);
    axi_bus.awaddr = addr; axi_bus.awlen = len; axi_bus.awsize = size;
    axi_bus.awburst = burst; axi_bus.awid = id; axi_bus.awvalid = 1'b1;
    for (int n = 0; n < 20 && !axi_bus.awready; n++) @(negedge clk);
    if (!axi_bus.awready) check("aw_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    axi_bus.awvalid = 1'b0;
  endtask

  task automatic ar_send(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [3:0] id);
    axi_bus.araddr = addr; axi_bus.arlen = len; axi_bus.arsize = size;
    axi_bus.arburst = burst; axi_bus.arid = id; axi_bus.arvalid = 1'b1;
    for (int n = 0; n < 20 && !axi_bus.arready; n++) @(negedge clk);
    if (!axi_bus.arready) check("ar_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    axi_bus.arvalid = 1'b0;
  endtask

  task automatic wr_beat(input logic [31:0] data, input logic [3:0] strb, input logic last);
    axi_bus.wdata = data; axi_bus.wstrb = strb; axi_bus.wlast = last; axi_bus.wvalid = 1'b1;
    for (int n = 0; n < 20 && !axi_bus.wready; n++) @(negedge clk);
    if (!axi_bus.wready) check("w_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    axi_bus.wvalid = 1'b0;
  endtask

  task automatic b_check(input string tag, input logic [1:0] exp_resp, input logic [3:0] exp_id);
    axi_bus.bready = 1'b1;
    for (int n = 0; n < 20 && !axi_bus.bvalid; n++) @(negedge clk);
    check({tag, "_bvalid"}, 32'(axi_bus.bvalid), 32'd1);
    check({tag, "_bresp"}, 32'(axi_bus.bresp), 32'(exp_resp));
    check({tag, "_bid"}, 32'(axi_bus.bid), 32'(exp_id));
    @(posedge clk); #1;
    axi_bus.bready = 1'b0;
  endtask

  task automatic rd_beat(input string tag, input int stall, input logic [31:0] exp_data,
                         input logic [1:0] exp_resp, input logic exp_last, input logic [3:0] exp_id);
    axi_bus.rready = (stall == 0);
    for (int n = 0; n < 20 && !axi_bus.rvalid; n++) @(negedge clk);
    check({tag, "_rvalid"}, 32'(axi_bus.rvalid), 32'd1);
    check({tag, "_rdata"}, axi_bus.rdata, exp_data);
    check({tag, "_rresp"}, 32'(axi_bus.rresp), 32'(exp_resp));
    check({tag, "_rlast"}, 32'(axi_bus.rlast), 32'(exp_last));
    check({tag, "_rid"}, 32'(axi_bus.rid), 32'(exp_id));
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check({tag, "_hold_rvalid"}, 32'(axi_bus.rvalid), 32'd1);
      check({tag, "_hold_rdata"}, axi_bus.rdata, exp_data);
    end
    axi_bus.rready = 1'b1;
    @(posedge clk); #1;
    axi_bus.rready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] last_w;
    logic        got_r;
    logic [31:0] wrap_exp [4];

    axi_bus.awvalid = 0; axi_bus.wvalid = 0; axi_bus.bready = 0;
    axi_bus.arvalid = 0; axi_bus.rready = 0;
    axi_bus.awid = 0; axi_bus.awaddr = 0; axi_bus.awlen = 0; axi_bus.awsize = 0; axi_bus.awburst = 0;
    axi_bus.wdata = 0; axi_bus.wstrb = 0; axi_bus.wlast = 0;
    axi_bus.arid = 4'h7; axi_bus.araddr = BASE + 32'h1000; axi_bus.arlen = 0;
    axi_bus.arsize = 3'd2; axi_bus.arburst = 2'b01;

    // Reset with a pending out-of-range read request
    axi_bus.arvalid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_awready", 32'(axi_bus.awready), 32'd0);
    check("rst_arready", 32'(axi_bus.arready), 32'd0);
    check("rst_bvalid", 32'(axi_bus.bvalid), 32'd0);
    check("rst_rvalid", 32'(axi_bus.rvalid), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_arready", 32'(axi_bus.arready), 32'd1);
    @(posedge clk); #1;
    axi_bus.arvalid = 1'b0;
    rd_beat("decerr", 0, 32'd0, 2'd3, 1'b1, 4'h7);

    // Preload words 0..3 with an INCR burst, then words 4 and 5
    aw_send(BASE, 8'd3, 3'd2, 2'b01, 4'h1);
    for (int i = 0; i < 4; i++) wr_beat(32'hA0A0_0000 + 32'(i), 4'hF, i == 3);
    b_check("init_b", 2'd0, 4'h1);
    aw_send(BASE + 32'h10, 8'd0, 3'd2, 2'b01, 4'h2);
    wr_beat(32'h1122_3344, 4'hF, 1'b1);
    b_check("w4_b", 2'd0, 4'h2);
    aw_send(BASE + 32'h14, 8'd0, 3'd2, 2'b01, 4'h2);
    wr_beat(32'h5555_5555, 4'hF, 1'b1);
    b_check("w5_b", 2'd0, 4'h2);

    // Byte-strobed single write, then read back with latency check
    aw_send(BASE + 32'h10, 8'd0, 3'd2, 2'b01, 4'h3);
    wr_beat(32'hDEAD_BEEF, 4'b0101, 1'b1);
    b_check("strb_b", 2'd0, 4'h3);
    ar_send(BASE + 32'h10, 8'd0, 3'd2, 2'b01, 4'h5);
    @(negedge clk);
    check("lat_rvalid_c1", 32'(axi_bus.rvalid), 32'd0);
    @(negedge clk);
    check("lat_rvalid_c2", 32'(axi_bus.rvalid), 32'd1);
    rd_beat("strb_rd", 0, 32'h11AD_33EF, 2'd0, 1'b1, 4'h5);

    // INCR read burst with rready stalls on alternate beats
    ar_send(BASE, 8'd3, 3'd2, 2'b01, 4'h6);
    for (int i = 0; i < 4; i++)
      rd_beat($sformatf("incr%0d", i), i % 2, 32'hA0A0_0000 + 32'(i), 2'd0, i == 3, 4'h6);

    // Early wlast on a two-beat burst
    aw_send(BASE + 32'h20, 8'd1, 3'd2, 2'b01, 4'h4);
    wr_beat(32'h0000_0008, 4'hF, 1'b1);
    b_check("early_wlast", 2'd2, 4'h4);

    // Illegal size: error response and no SRAM update
    aw_send(BASE + 32'h14, 8'd0, 3'd3, 2'b01, 4'h4);
    wr_beat(32'h0BAD_0BAD, 4'hF, 1'b1);
    b_check("size3", 2'd2, 4'h4);
    ar_send(BASE + 32'h14, 8'd0, 3'd2, 2'b01, 4'h4);
    rd_beat("size3_rd", 0, 32'h5555_5555, 2'd0, 1'b1, 4'h4);

    // Round-robin with both channels requesting continuously
    last_w = 32'd0;
    axi_bus.awaddr = BASE + 32'h18; axi_bus.awlen = 0; axi_bus.awsize = 3'd2;
    axi_bus.awburst = 2'b01; axi_bus.awid = 4'h1;
    axi_bus.araddr = BASE + 32'h18; axi_bus.arlen = 0; axi_bus.arsize = 3'd2;
    axi_bus.arburst = 2'b01; axi_bus.arid = 4'h2;
    axi_bus.awvalid = 1'b1; axi_bus.arvalid = 1'b1;
    for (int t = 0; t < 4; t++) begin
      for (int n = 0; n < 20 && !(axi_bus.awready || axi_bus.arready); n++) @(negedge clk);
      got_r = axi_bus.arready;
      check($sformatf("arb_grant%0d", t), 32'(got_r), 32'(t % 2));
      @(posedge clk); #1;
      if (got_r) begin
        axi_bus.arvalid = 1'b0;
        rd_beat($sformatf("arb_rd%0d", t), 0, last_w, 2'd0, 1'b1, 4'h2);
        if (t < 3) axi_bus.arvalid = 1'b1;
      end else begin
        axi_bus.awvalid = 1'b0;
        last_w = 32'h600D_0000 + 32'(t);
        wr_beat(last_w, 4'hF, 1'b1);
        b_check($sformatf("arb_b%0d", t), 2'd0, 4'h1);
        if (t < 3) axi_bus.awvalid = 1'b1;
      end
    end
    axi_bus.awvalid = 1'b0; axi_bus.arvalid = 1'b0;

    // WRAP read from word 2
`ifdef LETC_AXI_SRAM_SUB_WRAP_BURST_EN
    wrap_exp[0] = 32'hA0A0_0002; wrap_exp[1] = 32'hA0A0_0003;
    wrap_exp[2] = 32'hA0A0_0000; wrap_exp[3] = 32'hA0A0_0001;
    ar_send(BASE + 32'h8, 8'd3, 3'd2, 2'b10, 4'h9);
    for (int i = 0; i < 4; i++)
      rd_beat($sformatf("wrap%0d", i), 0, wrap_exp[i], 2'd0, i == 3, 4'h9);
`else
    wrap_exp[0] = 32'd0; wrap_exp[1] = 32'd0; wrap_exp[2] = 32'd0; wrap_exp[3] = 32'd0;
    ar_send(BASE + 32'h8, 8'd3, 3'd2, 2'b10, 4'h9);
    for (int i = 0; i < 4; i++)
      rd_beat($sformatf("wrap%0d", i), 0, wrap_exp[i], 2'd2, i == 3, 4'h9);
`endif

    // Reset while a read beat is waiting for rready
    ar_send(BASE, 8'd3, 3'd2, 2'b01, 4'hA);
    for (int n = 0; n < 20 && !axi_bus.rvalid; n++) @(negedge clk);
    check("midrst_rvalid_before", 32'(axi_bus.rvalid), 32'd1);
    rst = 1'b1;
    axi_bus.araddr = BASE + 32'h10; axi_bus.arlen = 0; axi_bus.arburst = 2'b01;
    axi_bus.arid = 4'hB; axi_bus.arvalid = 1'b1;
    @(negedge clk);
    check("midrst_rvalid", 32'(axi_bus.rvalid), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_idle_arready", 32'(axi_bus.arready), 32'd1);
    @(posedge clk); #1;
    axi_bus.arvalid = 1'b0;
    rd_beat("midrst_rd", 0, 32'h11AD_33EF, 2'd0, 1'b1, 4'hB);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/letc_axi_sram_sub.md
Name: letc_axi_sram_sub

Overview:
- AXI4 subordinate (responder) fronting an on-chip word-addressed SRAM. It answers the AXI manager traffic the LETC core issues.
- Handles one transaction at a time: single-beat, INCR and FIXED bursts, with byte-strobed writes.
- Sits on the SoC interconnect as the boot/scratch RAM target, and serves as the bench target for core AXI verification.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of word 0.
- DEPTH_WORDS, 1024, number of 32-bit words; must be a power of two, at least 2.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous, active-high reset.
- axi  axi_if.subordinate  -  modport carrying the following signals:
  - AW channel: awvalid/awready 1, awid ID_W, awaddr 32, awlen 8, awsize 3, awburst 2.
  - W channel: wvalid/wready 1, wdata 32, wstrb 4, wlast 1.
  - B channel: bvalid/bready 1, bid ID_W, bresp 2.
  - AR channel: arvalid/arready 1, arid ID_W, araddr 32, arlen 8, arsize 3, arburst 2.
  - R channel: rvalid/rready 1, rid ID_W, rdata 32, rresp 2, rlast 1.
  - ID_W is the axi_if ID width.

Behaviour:
- Reset, synchronous on i_clk while i_rst=1:
  - State IDLE.
  - awready, wready, bvalid, arready, rvalid, rlast = 0.
  - bresp, rresp, rdata, bid, rid = 0.
  - Arbitration bit = 0 (write first).
  - SRAM contents are not reset.
  - Reset mid-burst abandons the transaction; no B or R is issued.
- FSM states: IDLE, W_DATA, W_RESP, R_FETCH, R_DATA.
- IDLE:
  - awready and arready are asserted registered: high only in IDLE, and only for the channel the arbiter selects.
  - Both valid → the arbiter picks per the arbitration bit, then toggles the bit (round-robin).
  - Only one valid → that channel is taken.
  - On handshake, latch id, addr, len, size, burst; clear the error accumulator and beat counter.
- W_DATA:
  - wready=1.
  - Each W handshake writes the lanes with wstrb set to word (addr-BASE_ADDR)>>2, then advances addr by burst rules and increments the beat counter.
  - On wlast, go to W_RESP.
  - Beat count ≠ awlen+1 at wlast, or a beat past awlen+1 without wlast → record SLVERR. Keep consuming until wlast; suppress writes after beat awlen+1.
- W_RESP:
  - bvalid=1 with bid = latched id and bresp = accumulated error.
  - On bready → IDLE.
- R_FETCH:
  - One cycle: synchronous SRAM read of the current address.
  - Next cycle → R_DATA.
- R_DATA:
  - rvalid=1; rdata is registered and stable while rready=0.
  - rid = latched id; rresp per beat; rlast=1 when beat == arlen.
  - On handshake: if last → IDLE, else advance addr and go to R_FETCH.
  - Throughput is 1 beat per 2 cycles; first rvalid appears 2 cycles after the AR handshake.
- Address advance:
  - FIXED: unchanged.
  - INCR: addr += 1<<size, 32-bit wrap, no 4 KiB check.
- Response codes, error priority DECERR > SLVERR > OKAY:
  - Beat address outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS) → DECERR for that beat; the write is suppressed and read data is 0.
  - size>2, burst=2'b11, or WRAP without the feature → SLVERR for the whole transaction: no SRAM writes, all R beats return 0.
  - Writes accumulate the worst beat response into bresp; reads report rresp per beat.
- Reads return the full aligned word regardless of size; narrow writes rely on wstrb.

Optional Feature:
- Macro: LETC_AXI_SRAM_SUB_WRAP_BURST_EN.
- Defined: WRAP bursts (awburst/arburst=2'b10) are supported.
  - len must be 1, 3, 7 or 15; other lengths → SLVERR.
  - Wrap boundary = (len+1)<<size aligned; addr = boundary | ((addr + (1<<size)) mod span).
- Undefined: WRAP → SLVERR as above.

Decomposition:
- Shared package (letc_pkg):
  - axi_resp_e (OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3).
  - axi_burst_e (FIXED=0, INCR=1, WRAP=2).
  - Typedef for the latched AW/AR request struct.
- Module-local: FSM state enum, address-advance function.
- One natural sub-module: letc_sram_1rw, a single-port 32-bit SRAM with 4-bit byte write enable and 1-cycle registered read.

Test Plan:
- Reset: i_rst=1 for 3 cycles → awready, arready, bvalid, rvalid all 0; first cycle after release with arvalid=1 → arready=1.
- Single write/read:
  - AW addr=BASE+0x10, len=0, size=2; W data=0xDEADBEEF, strb=4'b0101 over prior 0x11223344 → bresp=OKAY.
  - Read back → rdata=0x11AD33EF, rlast=1, rvalid 2 cycles after AR.
- INCR read burst:
  - len=3 from BASE+0x0 with rready toggled 1,0,1,… → 4 beats of words 0..3, rdata held stable when stalled, rlast only on beat 4.
- Errors:
  - AR at BASE+4*DEPTH_WORDS → rresp=DECERR, rdata=0.
  - AW len=1 with wlast on the first beat → bresp=SLVERR.
  - AW size=3 → bresp=SLVERR, SRAM unchanged.
- Arbitration and mid-operation reset:
  - awvalid and arvalid held high together for 4 transactions → grant order W, R, W, R.
  - i_rst asserted during R_DATA → rvalid=0 next cycle, FSM in IDLE.
- WRAP (with macro):
  - AR addr=BASE+0x8, len=3, size=2 → words 2,3,0,1.
  - Without the macro, the same request → 4 beats, rresp=SLVERR.
